// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole spawner: tick prescaler, LFSR spawns, mole aging, round FSM
//
// Purpose:
//   Drives the active-mole vector consumed by the whack/hit stage. On every
//   game tick it clears hit moles, ages the survivors (retiring expired ones
//   as misses) and may spawn one new mole at an LFSR-chosen position.
//   The round FSM is IDLE -> RUN -> DONE; a start pulse (re)enters RUN.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse, begins or restarts a round
//   hit_reg       positions hit this cycle (from the whack stage)
//   moles         active mole vector (registered)
//   missed        one-cycle pulse per mole that expired unhit
//   tick          one-cycle pulse on every game tick while running
//   round_active  high while the round is running
//
// Optional feature macro: MOLE_SPEEDUP_EN
//   Defined: the tick period starts at TICK_CYCLES and shrinks by
//   TICK_CYCLES>>3 after every 8th tick of a round, floored at TICK_CYCLES>>2.
//   Undefined: fixed tick period of TICK_CYCLES.

module mole_spawner #(
  parameter int          N_MOLES     = 18,
  parameter int          TICK_CYCLES = 50_000_000,
  parameter int          LIFE_TICKS  = 3,
  parameter int          MAX_ACTIVE  = 4,
  parameter int          ROUND_TICKS = 60,
  parameter logic [19:0] LFSR_SEED   = 20'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] hit_reg,
  output logic [N_MOLES-1:0] moles,
  output logic [N_MOLES-1:0] missed,
  output logic               tick,
  output logic               round_active
);

  localparam int AGE_W = $clog2(LIFE_TICKS + 1);
  localparam int RND_W = $clog2(ROUND_TICKS + 1);
  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PER_W = $clog2(TICK_CYCLES + 1);
  localparam int CNT_W = $clog2(N_MOLES + 1);
  // An all-zero seed would lock the LFSR up.
  localparam logic [19:0] SEED = (LFSR_SEED == 20'd0) ? 20'd1 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [19:0]        lfsr;
  logic [PRE_W-1:0]   presc;
  logic [RND_W-1:0]   rnd_cnt;
  logic [RND_W-1:0]   rnd_next;
  logic [AGE_W-1:0]   age     [N_MOLES];
  logic [AGE_W-1:0]   age_inc [N_MOLES];
  logic [PER_W-1:0]   term_cnt;
  logic               presc_tc;
  logic               round_end;
  logic [N_MOLES-1:0] hit_mask;
  logic [N_MOLES-1:0] after_hit;
  logic [N_MOLES-1:0] expire;
  logic [N_MOLES-1:0] after_age;
  logic [N_MOLES-1:0] spawn_vec;
  logic [CNT_W-1:0]   active_cnt;
  logic [5:0]         cand;

`ifdef MOLE_SPEEDUP_EN
  localparam int STEP  = TICK_CYCLES >> 3;
  localparam int FLOOR = TICK_CYCLES >> 2;
  logic [PER_W-1:0] period;
  assign term_cnt = period - PER_W'(1);
`else
  assign term_cnt = PER_W'(TICK_CYCLES - 1);
`endif

  // >= rather than == keeps the prescaler from running away if the period
  // ever shrinks below the current count.
  assign presc_tc  = (PER_W'(presc) >= term_cnt);
  assign rnd_next  = rnd_cnt + RND_W'(1);
  assign round_end = (rnd_next == RND_W'(ROUND_TICKS));

  // Free-running Fibonacci LFSR, x^20 + x^17 + 1. Runs in every state so the
  // spawn pattern depends on when start is pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
    end
  end

  // Tick evaluation: hit clear, then aging/expiry, then one candidate spawn.
  always_comb begin
    hit_mask   = hit_reg & moles;
    after_hit  = moles & ~hit_mask;
    expire     = '0;
    spawn_vec  = '0;
    active_cnt = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      age_inc[i] = age[i] + AGE_W'(1);
      expire[i]  = after_hit[i] && (age_inc[i] == AGE_W'(LIFE_TICKS));
    end
    after_age = after_hit & ~expire;
    for (int i = 0; i < N_MOLES; i++) begin
      active_cnt = active_cnt + CNT_W'(after_age[i]);
    end
    cand = {1'b0, lfsr[4:0]};
    if (cand >= 6'(N_MOLES)) begin
      cand = cand - 6'(N_MOLES);
    end
    // A position hit on this edge may not respawn on the same edge.
    for (int i = 0; i < N_MOLES; i++) begin
      if ((cand == 6'(i)) && !after_age[i] && !hit_mask[i] &&
          (int'(active_cnt) < MAX_ACTIVE)) begin
        spawn_vec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      moles        <= '0;
      missed       <= '0;
      tick         <= 1'b0;
      round_active <= 1'b0;
      presc        <= '0;
      rnd_cnt      <= '0;
      for (int i = 0; i < N_MOLES; i++) age[i] <= '0;
`ifdef MOLE_SPEEDUP_EN
      period       <= PER_W'(TICK_CYCLES);
`endif
    end else begin
      missed <= '0;
      tick   <= 1'b0;
      if (start) begin
        state        <= RUN;
        round_active <= 1'b1;
        moles        <= '0;
        presc        <= '0;
        rnd_cnt      <= '0;
        for (int i = 0; i < N_MOLES; i++) age[i] <= '0;
`ifdef MOLE_SPEEDUP_EN
        period       <= PER_W'(TICK_CYCLES);
`endif
      end else begin
        case (state)
          IDLE: begin
            moles <= '0;
          end
          RUN: begin
            if (presc_tc) begin
              presc <= '0;
              tick  <= 1'b1;
            end else begin
              presc <= presc + PRE_W'(1);
            end
            // The tick pulse register doubles as the "evaluate tick" strobe,
            // so the mole update lands the cycle after tick is seen.
            if (!tick) begin
              moles <= moles & ~hit_reg;
              for (int i = 0; i < N_MOLES; i++) begin
                if (hit_mask[i]) age[i] <= '0;
              end
            end else if (round_end) begin
              state        <= DONE;
              round_active <= 1'b0;
              moles        <= '0;
              presc        <= '0;
              tick         <= 1'b0;
              rnd_cnt      <= rnd_next;
              for (int i = 0; i < N_MOLES; i++) age[i] <= '0;
            end else begin
              moles   <= after_age | spawn_vec;
              missed  <= expire;
              rnd_cnt <= rnd_next;
              for (int i = 0; i < N_MOLES; i++) begin
                if (hit_mask[i] || expire[i] || spawn_vec[i]) begin
                  age[i] <= '0;
                end else if (after_hit[i]) begin
                  age[i] <= age_inc[i];
                end
              end
`ifdef MOLE_SPEEDUP_EN
              if ((int'(rnd_next) % 8) == 0) begin
                if (period >= PER_W'(FLOOR + STEP)) begin
                  period <= period - PER_W'(STEP);
                end else begin
                  period <= PER_W'(FLOOR);
                end
              end
`endif
            end
          end
          DONE: begin
            moles        <= '0;
            round_active <= 1'b0;
          end
          default: begin
            state        <= IDLE;
            moles        <= '0;
            round_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - self-checking bench for mole_spawner against a behavioural game model

module tb_mole_spawner;

  localparam int N     = 18;
  localparam int TC    = 10;
  localparam int LIFE  = 3;
  localparam int MAXA  = 2;
  localparam int ROUND = 20;
`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEED = 1'b1;
`else
  localparam bit SPEED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] hit_reg;
  logic [N-1:0] moles;
  logic [N-1:0] missed;
  logic         tick;
  logic         round_active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mole_spawner #(
    .N_MOLES    (N),
    .TICK_CYCLES(TC),
    .LIFE_TICKS (LIFE),
    .MAX_ACTIVE (MAXA),
    .ROUND_TICKS(ROUND)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hit_reg     (hit_reg),
    .moles       (moles),
    .missed      (missed),
    .tick        (tick),
    .round_active(round_active)
  );

  // Game model: ages per position (-1 = no mole), cycles since round entry,
  // and the cycle number of the next expected tick.
  logic [19:0]  m_lfsr;
  int           m_st;      // 0 idle, 1 running, 2 done
  int           m_age [N];
  int           m_cyc, m_last, m_next, m_ticks, m_period;
  logic [N-1:0] e_moles, e_missed;
  logic         e_tick, e_active;

  function automatic logic [19:0] lfsr_adv(input logic [19:0] v);
    return {v[18:0], v[19] ^ v[16]};
  endfunction

  function automatic logic [19:0] lfsr_adv_n(input logic [19:0] v, input int n);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = lfsr_adv(t);
    return t;
  endfunction

  task automatic model_reset();
    m_lfsr = 20'hACE1;
    m_st = 0; m_cyc = 0; m_last = -100; m_next = 0; m_ticks = 0; m_period = TC;
    for (int i = 0; i < N; i++) m_age[i] = -1;
    e_moles = '0; e_missed = '0; e_tick = 1'b0; e_active = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [N-1:0] hr);
    logic [19:0]  cur;
    logic [N-1:0] hm;
    int           c, cnt;
    cur      = m_lfsr;
    m_lfsr   = lfsr_adv(m_lfsr);
    e_missed = '0;
    e_tick   = 1'b0;
    if (st) begin
      m_st = 1; m_cyc = 0; m_ticks = 0; m_period = TC; m_next = TC; m_last = -100;
      for (int i = 0; i < N; i++) m_age[i] = -1;
      e_active = 1'b1;
    end else if (m_st == 1) begin
      m_cyc++;
      hm = '0;
      for (int i = 0; i < N; i++) begin
        if (m_age[i] >= 0 && hr[i]) begin
          hm[i] = 1'b1;
          m_age[i] = -1;
        end
      end
      if (m_cyc == m_last + 1) begin
        m_ticks++;
        if (m_ticks == ROUND) begin
          m_st = 2;
          e_active = 1'b0;
          for (int i = 0; i < N; i++) m_age[i] = -1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (m_age[i] >= 0) begin
              m_age[i]++;
              if (m_age[i] == LIFE) begin
                m_age[i] = -1;
                e_missed[i] = 1'b1;
              end
            end
          end
          cnt = 0;
          for (int i = 0; i < N; i++) if (m_age[i] >= 0) cnt++;
          c = int'(cur[4:0]);
          if (c >= N) c -= N;
          if (cnt < MAXA && m_age[c] < 0 && !hm[c]) m_age[c] = 0;
          if (SPEED && (m_ticks % 8 == 0)) begin
            m_period -= TC / 8;
            if (m_period < TC / 4) m_period = TC / 4;
          end
          m_next = m_last + m_period;
        end
      end
      if (m_st == 1 && m_cyc == m_next) begin
        e_tick = 1'b1;
        m_last = m_cyc;
      end
    end
    for (int i = 0; i < N; i++) e_moles[i] = (m_age[i] >= 0);
  endtask

  // One clock: drive inputs, clock edge, sample 1 time unit later, advance model.
  task automatic cyc(input logic st, input logic [N-1:0] hr);
    start   = st;
    hit_reg = hr;
    @(posedge clk);
    #1;
    model_step(st, hr);
    start   = 1'b0;
    hit_reg = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hit_reg = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (moles !== '0) begin n_bad++; $display("FAIL reset_moles: got %h expected 0", moles); end
    n_cmp++; if (missed !== '0) begin n_bad++; $display("FAIL reset_missed: got %h expected 0", missed); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_cmp++; if (round_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b expected 0", round_active); end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Starts the round at a moment where tick 1 draws candidate 5 and tick 2
  // draws candidate 23 (which folds onto 5 and so collides).
  task automatic test_start_first_tick();
    logic [19:0] a11, a21;
    bit          found;
    found = 1'b0;
    for (int k = 0; k < 40000 && !found; k++) begin
      a11 = lfsr_adv_n(m_lfsr, 11);
      a21 = lfsr_adv_n(a11, 10);
      if (a11[4:0] == 5'd5 && a21[4:0] == 5'd23) found = 1'b1;
      else cyc(1'b0, '0);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL start_search: got no slot expected slot within bound"); end
    cyc(1'b1, '0);
    n_cmp++; if (round_active !== 1'b1) begin n_bad++; $display("FAIL start_active: got %b expected 1", round_active); end
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, '0);
      n_cmp++;
      if (tick !== (k == 10)) begin n_bad++; $display("FAIL first_tick c%0d: got %b expected %b", k, tick, (k == 10)); end
    end
    cyc(1'b0, '0);
    n_cmp++; if (moles !== 18'h00020) begin n_bad++; $display("FAIL first_spawn: got %h expected 00020", moles); end
    for (int k = 12; k <= 21; k++) cyc(1'b0, '0);
    n_cmp++; if (moles !== 18'h00020) begin n_bad++; $display("FAIL collision_23: got %h expected 00020", moles); end
  endtask

  task automatic test_expiry();
    for (int k = 22; k <= 42; k++) begin
      cyc(1'b0, '0);
      n_cmp++;
      if (missed !== ((k == 41) ? 18'h00020 : 18'h0)) begin
        n_bad++; $display("FAIL expiry c%0d: got %h expected %h", k, missed, (k == 41) ? 18'h00020 : 18'h0);
      end
      n_cmp++;
      if (moles !== e_moles) begin n_bad++; $display("FAIL expiry_moles c%0d: got %h expected %h", k, moles, e_moles); end
    end
  endtask

  task automatic test_hit();
    logic [N-1:0] b, prev;
    bit           done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (m_st == 1 && !e_tick && e_moles != '0) begin
        b = e_moles & (~e_moles + 1'b1);
        cyc(1'b0, b);
        n_cmp++; if ((moles & b) !== '0) begin n_bad++; $display("FAIL hit_clear: got %h expected bit %h clear", moles, b); end
        n_cmp++; if (missed !== '0) begin n_bad++; $display("FAIL hit_nomiss: got %h expected 0", missed); end
        n_cmp++; if (moles !== e_moles) begin n_bad++; $display("FAIL hit_moles: got %h expected %h", moles, e_moles); end
        done = 1'b1;
      end else begin
        cyc(1'b0, '0);
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hit_setup: got none expected active mole"); end
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (m_st == 1 && !e_tick && !e_moles[0]) begin
        prev = e_moles;
        cyc(1'b0, 18'h00001);
        n_cmp++; if (moles !== prev) begin n_bad++; $display("FAIL hit_inactive: got %h expected %h", moles, prev); end
        done = 1'b1;
      end else begin
        cyc(1'b0, '0);
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hit_inactive_setup: got none expected slot"); end
  endtask

  task automatic test_round_end();
    int exp_t [ROUND];
    int t, iv, nseen, k;
    t = 0; iv = TC;
    for (int j = 1; j <= ROUND; j++) begin
      t += iv;
      exp_t[j-1] = t;
      if (SPEED && j % 8 == 0) iv = (iv - TC / 8 < TC / 4) ? TC / 4 : iv - TC / 8;
    end
    cyc(1'b1, '0);
    nseen = 0;
    for (k = 1; k < 400; k++) begin
      cyc(1'b0, '0);
      if (tick) begin
        n_cmp++;
        if (nseen >= ROUND || k != exp_t[nseen]) begin
          n_bad++; $display("FAIL tick_time #%0d: got cycle %0d expected %0d", nseen, k, (nseen < ROUND) ? exp_t[nseen] : -1);
        end
        nseen++;
      end
      n_cmp++;
      if (moles !== e_moles) begin n_bad++; $display("FAIL round_moles c%0d: got %h expected %h", k, moles, e_moles); end
      if (!round_active) break;
    end
    n_cmp++; if (nseen !== ROUND) begin n_bad++; $display("FAIL round_ticks: got %0d expected %0d", nseen, ROUND); end
    n_cmp++; if (k !== exp_t[ROUND-1] + 1) begin n_bad++; $display("FAIL round_end_cycle: got %0d expected %0d", k, exp_t[ROUND-1] + 1); end
    cyc(1'b0, 18'h3FFFF);
    n_cmp++; if (moles !== '0) begin n_bad++; $display("FAIL done_moles: got %h expected 0", moles); end
    n_cmp++; if (round_active !== 1'b0) begin n_bad++; $display("FAIL done_active: got %b expected 0", round_active); end
  endtask

  task automatic test_restart();
    cyc(1'b1, '0);
    n_cmp++; if (round_active !== 1'b1) begin n_bad++; $display("FAIL restart_active: got %b expected 1", round_active); end
    for (int k = 0; k < 35; k++) cyc(1'b0, '0);
    cyc(1'b1, '0);
    n_cmp++; if (moles !== '0) begin n_bad++; $display("FAIL midrun_moles: got %h expected 0", moles); end
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, '0);
      n_cmp++;
      if (tick !== (k == 10)) begin n_bad++; $display("FAIL midrun_tick c%0d: got %b expected %b", k, tick, (k == 10)); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] hr;
    logic         st;
    int           r, j;
    for (int k = 0; k < 3000; k++) begin
      hr = '0;
      r  = $urandom_range(0, 9);
      if (r < 3 && e_moles != '0) begin
        j = $urandom_range(0, N - 1);
        for (int q = 0; q < N; q++) begin
          if (e_moles[(j + q) % N]) begin
            hr[(j + q) % N] = 1'b1;
            break;
          end
        end
      end else if (r == 3) begin
        hr[$urandom_range(0, N - 1)] = 1'b1;
      end else if (r == 4) begin
        hr = N'($urandom);
      end
      st = (m_st != 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
      cyc(st, hr);
      n_cmp++;
      if (moles !== e_moles || missed !== e_missed || tick !== e_tick || round_active !== e_active) begin
        n_bad++;
        $display("FAIL random c%0d: got m=%h x=%h t=%b a=%b expected m=%h x=%h t=%b a=%b",
                 k, moles, missed, tick, round_active, e_moles, e_missed, e_tick, e_active);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ready;
    ready = 1'b0;
    cyc(1'b1, '0);
    for (int k = 0; k < 600 && !ready; k++) begin
      cyc(1'b0, '0);
      if ($countones(e_moles) == 2 && m_st == 1) ready = 1'b1;
    end
    n_cmp++; if (!ready) begin n_bad++; $display("FAIL rst_setup: got <2 moles expected 2"); end
    n_cmp++; if (moles !== e_moles) begin n_bad++; $display("FAIL rst_pre_moles: got %h expected %h", moles, e_moles); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (moles !== '0) begin n_bad++; $display("FAIL rst_async_moles: got %h expected 0", moles); end
    n_cmp++; if (round_active !== 1'b0) begin n_bad++; $display("FAIL rst_async_active: got %b expected 0", round_active); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, '0);
    n_cmp++; if (round_active !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b expected 0", round_active); end
  endtask

  initial begin
    test_reset();
    test_start_first_tick();
    test_expiry();
    test_hit();
    test_round_end();
    test_restart();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
